stopwatch_lap: RTL
==================

Name: stopwatch_lap

Overview:
- Next-generation stopwatch core: parametrised tick prescaler, MM:SS:CC counting with saturation, and a lap buffer of depth LAP_DEPTH with recall mode.
- Sits between the button debounce/edge-detect front end and the two 6-bit LED number drivers.
- Fully synchronous to clock; replaces edge-clocked button logic with single-cycle command pulses.

Parameters:
- TICK_DIV, 5000, clock cycles per centisecond tick (>=2).
- PRE_W, 13, prescaler width; must satisfy 2^PRE_W >= TICK_DIV.
- LAP_DEPTH, 8, number of stored lap entries (power of two, >=2).
- LAP_AW, 3, log2(LAP_DEPTH).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- lap  in  1  single-cycle pulse; capture lap (running) or step recall (paused).
- clear  in  1  single-cycle pulse; zero time and laps (ignored while running).
- view_toggle  in  1  single-cycle pulse; swap SS:CC / MM:SS view.
- led_num0  out  6  left display value.
- led_num1  out  6  right display value.
- led_dot  out  1  high when displayed time has minutes > 0.
- running  out  1  high in RUNNING.
- recall  out  1  high in RECALL.
- lap_count  out  LAP_AW+1  number of stored laps, 0..LAP_DEPTH.
- lap_full  out  1  lap_count == LAP_DEPTH.
- overflow  out  1  sticky; time reached 59:59.99.

Behaviour:
- Reset: state IDLE; prescaler, cs, sec, min = 0; lap_count = 0; recall pointer = 0; view = SS:CC; auto_done = 0; overflow = 0; all outputs 0.
- Command priority within one cycle: clear > start_stop > lap > view_toggle; lower-priority pulses in the same cycle are discarded.
- States:
  - IDLE: start_stop -> RUNNING.
  - RUNNING: start_stop -> PAUSED; clear ignored.
  - PAUSED: start_stop -> RUNNING; lap with lap_count > 0 -> RECALL, pointer = 0; clear -> IDLE.
  - RECALL: lap advances pointer, wrapping at lap_count-1 -> 0; start_stop -> PAUSED; clear -> IDLE.
- Prescaler: increments only in RUNNING. Tick asserts in the cycle prescaler == TICK_DIV-1, and the prescaler returns to 0 on that cycle. It holds its value across pause. Clear zeroes it.
- Time update: registered on the tick cycle.
  - cs 0..99, sec 0..59, min 0..59; ripple carry within the same cycle.
  - At 59:59.99 a tick does not wrap: time holds, overflow = 1, and state forces PAUSED.
  - In PAUSED with overflow = 1, start_stop is ignored until clear.
- Lap capture (RUNNING only):
  - A lap pulse writes {min, sec, cs} as held in that cycle, i.e. the pre-increment value if a tick coincides.
  - Write goes to entry lap_count; lap_count increments; visible the next cycle.
  - When full, the capture is dropped and lap_count stays LAP_DEPTH.
  - Storage is a register array, LAP_DEPTH x 19 bits.
- Clear: zeroes time, prescaler, overflow, lap_count, pointer, auto_done, and sets view = SS:CC. Stored entries need not be erased.
- Display source:
  - RECALL: the lap entry at pointer.
  - Otherwise: the live time.
- View:
  - SS:CC: led_num0 = sec, led_num1 = cs.
  - MM:SS: led_num0 = min, led_num1 = sec.
- View control:
  - view_toggle is effective only when the displayed source has min > 0.
  - Auto-switch: the first time live min goes 0 -> 1 while auto_done = 0, the view is set to MM:SS and auto_done = 1.
  - Later toggles are honoured.
  - When the displayed source has min == 0, the displayed view is forced to SS:CC; the stored view bit is unchanged.
- led_dot = displayed-source min > 0. Outputs are combinational from registers: zero extra latency.
- Reset mid-operation: asynchronous return to the reset values above, regardless of state.

Test Plan:
- TICK_DIV=4. Reset, start_stop, run 400 cycles. Required: cs = 100 ticks worth, i.e. sec = 1, cs = 0; led_num0 = 1, led_num1 = 0; running = 1.
- Run 3 ticks, start_stop, wait 50 cycles, start_stop, run 3 ticks. Required: cs = 6; prescaler resumes from its held value.
- Preload by running to 00:59.99, then 1 tick. Required: min = 1, view auto MM:SS, led_num0 = 1, led_num1 = 0, led_dot = 1. Then view_toggle: led_num0 = 0 (sec), led_num1 = 0 (cs).
- Issue 9 lap pulses at distinct times while running (LAP_DEPTH=8). Required: lap_count = 8, lap_full = 1, ninth dropped. Pause, then lap x3: recall = 1, pointer 0, 1, 2 show entries 0-2. Then 7 more laps: pointer wraps to 1.
- Lap and tick in the same cycle at cs = 42. Required: stored cs = 42 and live cs = 43. Clear while running is ignored. Clear when paused gives IDLE with all counts 0.
- Run to 59:59.99 plus 1 tick. Required: time holds at 59:59.99, overflow = 1, running = 0; start_stop ignored. Assert reset mid-run: all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_lap_if.sv
// rtl/stopwatch_lap_if.sv - command pulse and display/status bundle for stopwatch_lap
//
// Command pulses (single cycle, from the button front end):
//   start_stop, lap, clear, view_toggle
// Display and status (combinational from the core's registers):
//   led_num0, led_num1 (6-bit LED numbers), led_dot, running, recall,
//   lap_count (0..2^LAP_AW), lap_full, overflow
// master: drives commands (front end / bench); slave: the stopwatch core.
interface stopwatch_lap_if #(
  parameter int LAP_AW = 3
);
  logic              start_stop;
  logic              lap;
  logic              clear;
  logic              view_toggle;
  logic [5:0]        led_num0;
  logic [5:0]        led_num1;
  logic              led_dot;
  logic              running;
  logic              recall;
  logic [LAP_AW:0]   lap_count;
  logic              lap_full;
  logic              overflow;

  modport master (
    output start_stop, lap, clear, view_toggle,
    input  led_num0, led_num1, led_dot, running, recall, lap_count, lap_full, overflow
  );

  modport slave (
    input  start_stop, lap, clear, view_toggle,
    output led_num0, led_num1, led_dot, running, recall, lap_count, lap_full, overflow
  );
endinterface

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - MM:SS:CC stopwatch with tick prescaler, lap buffer and recall
//
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high
//   sw    - stopwatch_lap_if.slave: command pulses in, LED numbers and status out
// Parameters: TICK_DIV clocks per centisecond, PRE_W prescaler width,
//   LAP_DEPTH lap entries (power of two), LAP_AW = log2(LAP_DEPTH).
module stopwatch_lap #(
  parameter int TICK_DIV  = 5000,
  parameter int PRE_W     = 13,
  parameter int LAP_DEPTH = 8,
  parameter int LAP_AW    = 3
) (
  input  logic           clock,
  input  logic           reset,
  stopwatch_lap_if.slave sw
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, RECALL} state_t;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [LAP_AW:0]   CNT_FULL = (LAP_AW + 1)'(LAP_DEPTH);

  state_t              state, state_next;
  logic [PRE_W-1:0]    pre;
  logic [6:0]          cs;
  logic [5:0]          sec;
  logic [5:0]          min_q;
  logic [LAP_AW:0]     lap_cnt;
  logic [LAP_AW-1:0]   ptr;
  logic                view_mm;
  logic                auto_done;
  logic                ovf;
  logic [18:0]         lap_mem [LAP_DEPTH];

  // Priority decode: clear > start_stop > lap > view_toggle.
  logic cmd_clear, cmd_ss, cmd_lap, cmd_view;
  always_comb begin
    cmd_clear = sw.clear;
    cmd_ss    = sw.start_stop & ~sw.clear;
    cmd_lap   = sw.lap & ~sw.start_stop & ~sw.clear;
    cmd_view  = sw.view_toggle & ~sw.lap & ~sw.start_stop & ~sw.clear;
  end

  logic tick, at_max, lap_is_full, ptr_wrap;
  assign tick        = (state == RUNNING) && (pre == PRE_LAST);
  assign at_max      = (cs == 7'd99) && (sec == 6'd59) && (min_q == 6'd59);
  assign lap_is_full = (lap_cnt == CNT_FULL);
  assign ptr_wrap    = ((LAP_AW + 1)'(ptr) + (LAP_AW + 1)'(1)) == lap_cnt;

  // Displayed source: a stored lap in RECALL, otherwise the live time.
  logic [18:0] src;
  logic [5:0]  src_min, src_sec;
  logic [6:0]  src_cs;
  logic        show_mm;
  assign src     = (state == RECALL) ? lap_mem[ptr] : {min_q, sec, cs};
  assign src_min = src[18:13];
  assign src_sec = src[12:7];
  assign src_cs  = src[6:0];
  // MM:SS is only shown while there are minutes to show; the stored bit is kept.
  assign show_mm = view_mm && (src_min != 6'd0);

  logic do_clear, do_capture, ptr_start, ptr_step;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    ptr_start  = 1'b0;
    ptr_step   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_clear)   do_clear = 1'b1;
        else if (cmd_ss) state_next = RUNNING;
      end
      RUNNING: begin
        // Reaching 59:59.99 stops the watch just like a start_stop.
        if (cmd_ss || (tick && at_max)) state_next = PAUSED;
        if (cmd_lap && !lap_is_full)    do_capture = 1'b1;
      end
      PAUSED: begin
        if (cmd_clear) begin
          do_clear   = 1'b1;
          state_next = IDLE;
        end else if (cmd_ss) begin
          if (!ovf) state_next = RUNNING;
        end else if (cmd_lap && (lap_cnt != '0)) begin
          ptr_start  = 1'b1;
          state_next = RECALL;
        end
      end
      RECALL: begin
        if (cmd_clear) begin
          do_clear   = 1'b1;
          state_next = IDLE;
        end else if (cmd_ss) begin
          state_next = PAUSED;
        end else if (cmd_lap) begin
          ptr_step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      cs        <= '0;
      sec       <= '0;
      min_q     <= '0;
      lap_cnt   <= '0;
      ptr       <= '0;
      view_mm   <= 1'b0;
      auto_done <= 1'b0;
      ovf       <= 1'b0;
    end else if (do_clear) begin
      pre       <= '0;
      cs        <= '0;
      sec       <= '0;
      min_q     <= '0;
      lap_cnt   <= '0;
      ptr       <= '0;
      view_mm   <= 1'b0;
      auto_done <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (state == RUNNING) pre <= tick ? '0 : pre + PRE_W'(1);
      if (cmd_view && (src_min != 6'd0)) view_mm <= ~view_mm;
      if (tick) begin
        if (at_max) begin
          ovf <= 1'b1;
        end else if (cs != 7'd99) begin
          cs <= cs + 7'd1;
        end else begin
          cs <= '0;
          if (sec != 6'd59) begin
            sec <= sec + 6'd1;
          end else begin
            sec   <= '0;
            min_q <= min_q + 6'd1;
            // First 0 -> 1 minute rollover switches to MM:SS once.
            if ((min_q == 6'd0) && !auto_done) begin
              view_mm   <= 1'b1;
              auto_done <= 1'b1;
            end
          end
        end
      end
      if (do_capture) lap_cnt <= lap_cnt + (LAP_AW + 1)'(1);
      if (ptr_start)     ptr <= '0;
      else if (ptr_step) ptr <= ptr_wrap ? '0 : ptr + LAP_AW'(1);
    end
  end

  // Captures the pre-increment time when a tick lands in the same cycle.
  always_ff @(posedge clock) begin
    if (do_capture) lap_mem[lap_cnt[LAP_AW-1:0]] <= {min_q, sec, cs};
  end

  assign sw.led_num0  = show_mm ? src_min : src_sec;
  // Centiseconds above 63 do not fit the 6-bit driver; the low bits are shown.
  assign sw.led_num1  = show_mm ? src_sec : 6'(src_cs);
  assign sw.led_dot   = (src_min != 6'd0);
  assign sw.running   = (state == RUNNING);
  assign sw.recall    = (state == RECALL);
  assign sw.lap_count = lap_cnt;
  assign sw.lap_full  = lap_is_full;
  assign sw.overflow  = ovf;

endmodule
